mem_access_stage: RTL and testbench

- Pipelined-core MEM stage, directly downstream of the execute stage.
- Consumes the EX/MEM-registered ALU result (`valE`), forwarded store operand (`b_input`) and control; performs LB/LH/LW/LD(U) and SB/SH/SW/SD over a ready/valid data-memory port.
- Owns the MEM/WB register.
- Supplies the `meminput` forwarding value back to execute; stalls upstream while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 38 +++
 rtl/mem_access_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states
// and the byte-strobe lookup.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  function automatic logic [7:0] size_strb(input logic [1:0] size);
    logic [7:0] s;
    unique case (size)
      2'b00:   s = 8'h01;
      2'b01:   s = 8'h03;
      2'b10:   s = 8'h0F;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store shift/strobes and load extract/extend.
// Purely combinational; offsets are byte positions inside a doubleword.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_st_data,
  input  logic [2:0]      i_st_off,
  input  logic [1:0]      i_st_size,
  output logic [XLEN-1:0] o_wdata,
  output logic [7:0]      o_wstrb,
  input  logic [XLEN-1:0] i_ld_rdata,
  input  logic [2:0]      i_ld_off,
  input  logic [2:0]      i_ld_f3,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_raw;

  assign o_wdata = i_st_data << {i_st_off, 3'b000};
  assign o_wstrb = size_strb(i_st_size) << i_st_off;
  assign w_raw   = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = w_raw;
    case (i_ld_f3)
      F3_LB:  o_ld_data = {{(XLEN-8){w_raw[7]}}, w_raw[7:0]};
      F3_LH:  o_ld_data = {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
      F3_LW:  o_ld_data = {{(XLEN-32){w_raw[31]}}, w_raw[31:0]};
      F3_LBU: o_ld_data = {{(XLEN-8){1'b0}}, w_raw[7:0]};
      F3_LHU: o_ld_data = {{(XLEN-16){1'b0}}, w_raw[15:0]};
      F3_LWU: o_ld_data = {{(XLEN-32){1'b0}}, w_raw[31:0]};
      default: o_ld_data = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory access FSM and the MEM/WB register.
// An aligned memory op is consumed on entry; stall holds the next one.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   mem_fwd_data,
  output logic              misalign
);

  state_t r_state, w_next;

  logic [XLEN-1:0]   r_addr;
  logic [2:0]        r_off;
  logic [2:0]        r_f3;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic [7:0]        r_wstrb;
  logic [REG_AW-1:0] r_rd;
  logic              r_rw;
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rw;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_misalign;

  logic              w_mem_op;
  logic              w_misal;
  logic              w_go;
  logic [XLEN-1:0]   w_st_wdata;
  logic [7:0]        w_st_wstrb;
  logic [XLEN-1:0]   w_ld_data;

  assign w_mem_op = ex_mem_read | ex_mem_write;

  always_comb begin
    w_misal = 1'b0;
    unique case (ex_funct3[1:0])
      2'b00: w_misal = 1'b0;
      2'b01: w_misal = ex_alu_result[0];
      2'b10: w_misal = |ex_alu_result[1:0];
      2'b11: w_misal = |ex_alu_result[2:0];
    endcase
    if (ex_funct3 == F3_BAD) w_misal = 1'b1;
  end

  assign w_go = ex_valid & w_mem_op & ~w_misal;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .i_st_data  (ex_store_data),
    .i_st_off   (ex_alu_result[2:0]),
    .i_st_size  (ex_funct3[1:0]),
    .o_wdata    (w_st_wdata),
    .o_wstrb    (w_st_wstrb),
    .i_ld_rdata (dmem_rdata),
    .i_ld_off   (r_off),
    .i_ld_f3    (r_f3),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_REQ;
      S_REQ:  if (dmem_ready) w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT: if (dmem_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_off      <= '0;
      r_f3       <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rd       <= '0;
      r_rw       <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      // The slot is a bubble unless one of the cases below fills it.
      r_wb_valid <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_misalign <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (ex_valid && !w_mem_op) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= ex_rd;
            r_wb_rw    <= ex_reg_write;
            r_wb_data  <= ex_alu_result;
          end else if (ex_valid && w_misal) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= ex_rd;
            r_wb_data  <= ex_alu_result;
            r_misalign <= 1'b1;
          end else if (w_go) begin
            r_addr  <= {ex_alu_result[XLEN-1:3], 3'b000};
            r_off   <= ex_alu_result[2:0];
            r_f3    <= ex_funct3;
            r_we    <= ex_mem_write;
            r_wdata <= w_st_wdata;
            r_wstrb <= w_st_wstrb;
            r_rd    <= ex_rd;
            r_rw    <= ex_reg_write;
          end
        end
        S_REQ: begin
          if (dmem_ready && r_we) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= {r_addr[XLEN-1:3], r_off};
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_rw    <= r_rw;
            r_wb_data  <= w_ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall        = (r_state != S_IDLE);
  assign dmem_req     = (r_state == S_REQ);
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign dmem_wstrb   = r_wstrb;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_rw;
  assign wb_data      = r_wb_data;
  assign mem_fwd_data = r_wb_data;
  assign misalign     = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a writeback scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [63:0] wb_data;
  logic [63:0] mem_fwd_data;
  logic        misalign;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_ready    (dmem_ready),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .mem_fwd_data  (mem_fwd_data),
    .misalign      (misalign)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        chk_data;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] rd, input logic rw,
                      input logic cd, input logic [63:0] d,
                      input logic mis);
    exp_t e;
    e.rd = rd; e.rw = rw; e.chk_data = cd; e.data = d; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic drive(input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input logic [4:0] rd,
                       input logic rw);
    ex_valid = 1'b1; ex_mem_read = mr; ex_mem_write = mw;
    ex_funct3 = f3; ex_alu_result = a; ex_store_data = sd;
    ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_reg_write = 1'b0;
  endtask

  task automatic do_load(input logic [63:0] a, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] rdat,
                         input logic [63:0] exp);
    logic [63:0] al;
    al = {a[63:3], 3'b000};
    dmem_ready = 1'b1;
    drive(1'b1, 1'b0, f3, a, 64'h0, rd, 1'b1);
    push(rd, 1'b1, 1'b1, exp, 1'b0);
    tick();
    idle_ex();
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, al);
    tick();
    chk("ld_wait_stall", stall, 1);
    chk("ld_wait_req", dmem_req, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdat;
    tick();
    dmem_rvalid = 1'b0;
    chk("ld_wbv", wb_valid, 1);
    chk("ld_stall_done", stall, 0);
  endtask

  // Writeback monitor: every valid slot must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", wb_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_reg_write", wb_reg_write, e.rw);
        chk("wb_misalign", misalign, e.mis);
        if (e.chk_data) begin
          chk("wb_data", wb_data, e.data);
          chk("fwd_data", mem_fwd_data, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_funct3 = '0;
    idle_ex();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    reset = 1'b0;

    // ALU pass-through
    drive(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1);
    push(5'd5, 1'b1, 1'b1, 64'h1234, 1'b0);
    chk("alu_stall0", stall, 0);
    tick();
    idle_ex();
    chk("alu_wbv", wb_valid, 1);
    chk("alu_stall1", stall, 0);
    tick();
    chk("alu_bubble", wb_valid, 0);

    // SB at 0x1003, ready immediately
    dmem_ready = 1'b1;
    drive(1'b0, 1'b1, 3'b000, 64'h1003, 64'hAB, 5'd0, 1'b0);
    push(5'd0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    idle_ex();
    chk("sb_stall", stall, 1);
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_addr", dmem_addr, 64'h1000);
    chk("sb_wstrb", dmem_wstrb, 8'h08);
    chk("sb_wdata", dmem_wdata, 64'h0000_0000_AB00_0000);
    tick();
    chk("sb_stall_end", stall, 0);
    chk("sb_wbv", wb_valid, 1);

    // SH at 0x1006: upper bits of store data shift out
    drive(1'b0, 1'b1, 3'b001, 64'h1006, 64'h1234_5678_CAFE, 5'd0, 1'b0);
    push(5'd0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    idle_ex();
    chk("sh_wstrb", dmem_wstrb, 8'hC0);
    chk("sh_wdata", dmem_wdata, 64'hCAFE_0000_0000_0000);
    tick();
    chk("sh_wbv", wb_valid, 1);

    // Loads with immediate ready and next-cycle rvalid
    do_load(64'h2006, 3'b001, 5'd7, 64'h8001_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_8001);
    do_load(64'h2006, 3'b101, 5'd8, 64'h8001_0000_0000_0000,
            64'h0000_0000_0000_8001);
    do_load(64'h3005, 3'b000, 5'd10, 64'h0000_8000_0000_0000,
            64'hFFFF_FFFF_FFFF_FF80);
    do_load(64'h5004, 3'b110, 5'd11, 64'h8765_4321_0000_0000,
            64'h0000_0000_8765_4321);
    do_load(64'h5004, 3'b010, 5'd12, 64'h8765_4321_0000_0000,
            64'hFFFF_FFFF_8765_4321);

    // LD with ready delayed 3 cycles, rvalid 2 more
    dmem_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b011, 64'h4008, 64'h0, 5'd9, 1'b1);
    push(5'd9, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    tick();
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      chk("ld_hold_req", dmem_req, 1);
      chk("ld_hold_addr", dmem_addr, 64'h4008);
      chk("ld_hold_stall", stall, 1);
      if (i == 2) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("ld_w_stall", stall, 1);
      chk("ld_w_req", dmem_req, 0);
      chk("ld_w_wbv", wb_valid, 0);
      if (i == 1) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h0123_4567_89AB_CDEF;
      end
      tick();
    end
    dmem_rvalid = 1'b0;
    chk("ld_slow_wbv", wb_valid, 1);
    chk("ld_slow_stall", stall, 0);

    // Misaligned LW, then an ALU op proves the FSM stayed idle
    dmem_ready = 1'b1;
    drive(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 5'd3, 1'b1);
    push(5'd3, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 5'd6, 1'b1);
    push(5'd6, 1'b1, 1'b1, 64'h77, 1'b0);
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stall, 0);
    chk("mis_flag", misalign, 1);
    chk("mis_wbv", wb_valid, 1);
    chk("mis_rw", wb_reg_write, 0);
    tick();
    idle_ex();
    chk("mis_next_wbv", wb_valid, 1);
    chk("mis_next_flag", misalign, 0);

    // funct3=111 takes the misalign path even when aligned
    drive(1'b1, 1'b0, 3'b111, 64'h6000, 64'h0, 5'd2, 1'b1);
    push(5'd2, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    idle_ex();
    chk("bad_req", dmem_req, 0);
    chk("bad_flag", misalign, 1);
    tick();

    // Reset in WAIT, then a late rvalid must be ignored
    drive(1'b1, 1'b0, 3'b010, 64'h6000, 64'h0, 5'd4, 1'b1);
    tick();
    idle_ex();
    chk("abort_req", dmem_req, 1);
    tick();
    chk("abort_wait", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_stall", stall, 0);
    chk("abort_wbv", wb_valid, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_wbv", wb_valid, 0);
    chk("late_stall", stall, 0);
    chk("late_req", dmem_req, 0);
    tick();
    chk("late_wbv2", wb_valid, 0);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
